// File: rtl/regdisp_pkg.sv
// ---------------------------------------------------------------------------
// regdisp_pkg : shared constants for the register display scanner
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regdisp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; the entry for hex F is written first.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

`default_nettype wire

// File: rtl/reg_display_scan_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg  : combinational hex nibble to active-low seven-segment glyph
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex7seg
    import regdisp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPH_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/reg_display_scan.sv
// ---------------------------------------------------------------------------
// reg_display_scan : reads the datapath register file through its debug port
//                    and scans the value onto a 4-digit seven-segment display.
// Build option     : REGDISP_BLANK_EN enables leading-zero blanking.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_display_scan
    import regdisp_pkg::*;
#(
    parameter int DIGIT_DIV = 1000,
    parameter int DWELL     = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            sw_sel,
    input  logic                  auto_en,
    input  logic [15:0]           regdata,
    output logic [2:0]            regaddr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int DIV_W   = $clog2(DIGIT_DIV);
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIGIT_W-1:0] r_digit_idx;
    logic [DWELL_W-1:0] r_dwell;
    logic [15:0]        r_shadow;

    logic               w_div_tc;
    logic               w_frame_end;
    logic [DIGIT_W-1:0] w_digit_next;
    logic [15:0]        w_shadow_next;
    logic [3:0]         w_nibble;
    logic [6:0]         w_glyph;
    logic               w_blank;

    assign w_div_tc      = (r_div_cnt == DIV_W'(DIGIT_DIV - 1));
    assign w_frame_end   = w_div_tc && (r_digit_idx == DIGIT_W'(NUM_DIGITS - 1));
    assign w_digit_next  = w_div_tc ? r_digit_idx + 1'b1 : r_digit_idx;
    assign w_shadow_next = w_frame_end ? regdata : r_shadow;

    // Outputs are registered from next-state values so an/seg move with digit_idx.
    assign w_nibble = w_shadow_next[{w_digit_next, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (w_nibble),
        .seg    (w_glyph)
    );

`ifdef REGDISP_BLANK_EN
    assign w_blank = (w_digit_next != '0) &&
                     ((w_shadow_next >> {w_digit_next, 2'b00}) == 16'h0000);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_digit_idx <= '0;
            r_dwell     <= '0;
            r_shadow    <= 16'h0000;
            regaddr     <= 3'd0;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            r_div_cnt   <= w_div_tc ? '0 : r_div_cnt + 1'b1;
            r_digit_idx <= w_digit_next;
            r_shadow    <= w_shadow_next;
            an          <= ~(NUM_DIGITS'(1) << w_digit_next);
            seg         <= w_blank ? SEG_BLANK : w_glyph;
            dp          <= ~((w_digit_next == '0) && auto_en);

            // The shadow taken on an address-advance edge still belongs to the old register.
            if (!auto_en) begin
                regaddr <= sw_sel;
                r_dwell <= '0;
            end else if (w_frame_end) begin
                if (r_dwell == DWELL_W'(DWELL - 1)) begin
                    r_dwell <= '0;
                    regaddr <= regaddr + 3'd1;
                end else begin
                    r_dwell <= r_dwell + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_display_scan.sv
// ---------------------------------------------------------------------------
// tb_reg_display_scan : scoreboard bench for reg_display_scan
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_display_scan;

    localparam int DIGIT_DIV = 4;
    localparam int DWELL     = 2;
    localparam int FRAME     = 4 * DIGIT_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sw_sel;
    logic        auto_en;
    logic [15:0] regdata;
    logic [2:0]  regaddr;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [15:0] regfile [8];

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] addr;
    } exp_t;

    exp_t q[$];

    int total  = 0;
    int passed = 0;

    // Reference model state: edges since reset, latched value, address, frames on this address.
    int          m_n;
    logic [15:0] m_shadow;
    logic [2:0]  m_addr;
    int          m_frames;

    always #5 clk = ~clk;

    // The bench plays the datapath: regdata follows the requested register.
    assign regdata = regfile[regaddr];

    reg_display_scan #(
        .DIGIT_DIV (DIGIT_DIV),
        .DWELL     (DWELL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_sel  (sw_sel),
        .auto_en (auto_en),
        .regdata (regdata),
        .regaddr (regaddr),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [15:0] val, input int k);
        logic [15:0] upper;
        upper = val >> (4 * k);
`ifdef REGDISP_BLANK_EN
        if (k > 0 && upper == 16'h0000) return 7'b1111111;
`endif
        return glyph(upper[3:0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Applies the model for the edge just taken, using the inputs that were held into it.
    task automatic step();
        exp_t e;
        int   digit;
        bit   fe;
        @(posedge clk);
        if (reset) begin
            m_n = 0; m_shadow = 16'h0000; m_addr = 3'd0; m_frames = 0;
            e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.addr = 3'd0;
        end else begin
            m_n++;
            fe = (m_n % FRAME) == 0;
            if (fe) m_shadow = regfile[m_addr];
            if (!auto_en) begin
                m_addr   = sw_sel;
                m_frames = 0;
            end else if (fe) begin
                m_frames++;
                if (m_frames == DWELL) begin
                    m_frames = 0;
                    m_addr   = m_addr + 3'd1;
                end
            end
            digit  = (m_n / DIGIT_DIV) % 4;
            e.an   = ~(4'b0001 << digit);
            e.seg  = digit_seg(m_shadow, digit);
            e.dp   = !(digit == 0 && auto_en);
            e.addr = m_addr;
        end
        q.push_back(e);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an",      an,      e.an);
            chk("seg",     seg,     e.seg);
            chk("dp",      dp,      e.dp);
            chk("regaddr", regaddr, e.addr);
        end
    end

    initial begin
        reset = 1'b1; auto_en = 1'b0; sw_sel = 3'd5;
        for (int i = 0; i < 8; i++) regfile[i] = 16'($urandom);
        regfile[5] = 16'h1A2F;
        regfile[3] = 16'h0030;
        regfile[2] = 16'h0F00;
        regfile[1] = 16'h0000;

        repeat (3) step();
        reset = 1'b0;

        // Manual mode with occasional switch changes.
        for (int i = 0; i < 200; i++) begin
            if (i >= 40 && $urandom_range(0, 39) == 0) sw_sel = 3'($urandom);
            step();
        end

        // Auto mode from a fresh reset, past the 7->0 wrap.
        reset = 1'b1; auto_en = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (300) step();

        // Mixed: mode toggles, switch changes and mid-frame resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 29) == 0) sw_sel = 3'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        repeat (40) step();

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
